intersection_scheduler: RTL



---
 rtl/intersection_scheduler_pkg.sv | 48 ++++
 rtl/intersection_scheduler_phase_timer.sv | 26 ++
 rtl/intersection_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/intersection_scheduler_pkg.sv
// Shared definitions for the 4th Ave / Harrison phase scheduler: light codes,
// one-hot state encodings, Grant bit positions and the round-robin helper.
package intersection_scheduler_pkg;

  localparam logic [1:0] LC_FLASH  = 2'b00;
  localparam logic [1:0] LC_GREEN  = 2'b01;
  localparam logic [1:0] LC_YELLOW = 2'b10;
  localparam logic [1:0] LC_RED    = 2'b11;

  localparam int GRANT_NS  = 0;
  localparam int GRANT_EW  = 1;
  localparam int GRANT_PED = 2;

  typedef enum logic [6:0] {
    ST_FLASH   = 7'b000_0001,
    ST_ALL_RED = 7'b000_0010,
    ST_NS_G    = 7'b000_0100,
    ST_NS_Y    = 7'b000_1000,
    ST_EW_G    = 7'b001_0000,
    ST_EW_Y    = 7'b010_0000,
    ST_WALK    = 7'b100_0000
  } state_t;

  function automatic logic [7:0] clamp_dur(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

  // One-hot winner, searching upward starting just after the one-hot 'last'.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [2:0] last);
    logic [2:0] w;
    w = 3'b000;
    if (last == 3'b001) begin
      if (req[1])      w = 3'b010;
      else if (req[2]) w = 3'b100;
      else if (req[0]) w = 3'b001;
    end else if (last == 3'b010) begin
      if (req[2])      w = 3'b100;
      else if (req[0]) w = 3'b001;
      else if (req[1]) w = 3'b010;
    end else begin
      if (req[0])      w = 3'b001;
      else if (req[1]) w = 3'b010;
      else if (req[2]) w = 3'b100;
    end
    return w;
  endfunction

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// 8-bit loadable down-counter paced by Tick; expire flags the last Tick of a phase.
module intersection_scheduler_phase_timer #(
  parameter logic [7:0] RESET_VALUE = 8'd1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] value,
  input  logic       Tick,
  output logic       expire
);

  logic [7:0] count;

  always_ff @(posedge Clock) begin
    if (Reset)
      count <= RESET_VALUE;
    else if (load)
      count <= value;
    else if (Tick && (count != 8'd0))
      count <= count - 8'd1;
  end

  assign expire = Tick && (count == 8'd1);

endmodule

// File: rtl/intersection_scheduler.sv
// Round-robin phase sequencer for the 4th Ave / Harrison intersection.
// state   | meaning
// FLASH   | post-reset fail-safe, all lamps dark/flashing
// ALL_RED | clearance interval, arbitration point
// NS_G/Y  | NB 4th Ave green / yellow
// EW_G/Y  | EB+WB Harrison green / yellow
// WALK    | pedestrian phase, all vehicles red
module intersection_scheduler
  import intersection_scheduler_pkg::*;
#(
  parameter int NS_GREEN_T = 45,
  parameter int EW_GREEN_T = 15,
  parameter int YELLOW_T   = 5,
  parameter int RED_T      = 1,
  parameter int WALK_T     = 10,
  parameter int FLASH_T    = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       P,
  output logic [1:0] L1,
  output logic [1:0] L2,
  output logic [1:0] L3,
  output logic       Walk,
  output logic [2:0] Grant
);

  localparam logic [7:0] NS_DUR    = clamp_dur(8'(NS_GREEN_T));
  localparam logic [7:0] EW_DUR    = clamp_dur(8'(EW_GREEN_T));
  localparam logic [7:0] YEL_DUR   = clamp_dur(8'(YELLOW_T));
  localparam logic [7:0] RED_DUR   = clamp_dur(8'(RED_T));
  localparam logic [7:0] WALK_DUR  = clamp_dur(8'(WALK_T));
  localparam logic [7:0] FLASH_DUR = clamp_dur(8'(FLASH_T));

  state_t     state, state_nxt;
  logic [2:0] pend, pend_clr, last, last_nxt, win;
  logic [7:0] load_val;
  logic       expire;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_FLASH;
      pend  <= 3'b000;
      last  <= 3'b100;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      pend  <= (pend | {P, S2 | S3, S1}) & ~pend_clr;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    pend_clr  = 3'b000;
    win       = rr_pick(pend, last);
    if (expire) begin
      case (state)
        ST_FLASH:   state_nxt = ST_ALL_RED;
        ST_ALL_RED: begin
          if (win != 3'b000) begin
            last_nxt  = win;
            pend_clr  = win;
            state_nxt = win[0] ? ST_NS_G : (win[1] ? ST_EW_G : ST_WALK);
          end
        end
        ST_NS_G:    if (pend[1] || pend[2]) state_nxt = ST_NS_Y;
        ST_EW_G:    if (pend[0] || pend[2]) state_nxt = ST_EW_Y;
        ST_NS_Y, ST_EW_Y, ST_WALK: state_nxt = ST_ALL_RED;
        default:    state_nxt = ST_FLASH;
      endcase
    end
    // Every expiry reloads, so an unchanged state restarts its own interval.
    case (state_nxt)
      ST_FLASH:         load_val = FLASH_DUR;
      ST_NS_G:          load_val = NS_DUR;
      ST_EW_G:          load_val = EW_DUR;
      ST_NS_Y, ST_EW_Y: load_val = YEL_DUR;
      ST_WALK:          load_val = WALK_DUR;
      default:          load_val = RED_DUR;
    endcase
  end

  intersection_scheduler_phase_timer #(
    .RESET_VALUE(FLASH_DUR)
  ) u_phase_timer (
    .Clock (Clock),
    .Reset (Reset),
    .load  (expire),
    .value (load_val),
    .Tick  (Tick),
    .expire(expire)
  );

  always_comb begin
    L1    = LC_RED;
    L2    = LC_RED;
    L3    = LC_RED;
    Walk  = 1'b0;
    Grant = 3'b000;
    case (state)
      ST_FLASH: begin
        L1 = LC_FLASH;
        L2 = LC_FLASH;
        L3 = LC_FLASH;
      end
      ST_NS_G: begin
        L1              = LC_GREEN;
        Grant[GRANT_NS] = 1'b1;
      end
      ST_NS_Y: L1 = LC_YELLOW;
      ST_EW_G: begin
        L2              = LC_GREEN;
        L3              = LC_GREEN;
        Grant[GRANT_EW] = 1'b1;
      end
      ST_EW_Y: begin
        L2 = LC_YELLOW;
        L3 = LC_YELLOW;
      end
      ST_WALK: begin
        Walk             = 1'b1;
        Grant[GRANT_PED] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
